// File: rtl/ascii_serial_tx.sv
// Asynchronous-frame serial transmitter: start bit, LSB-first data, optional parity, stop bit.
// Define ASCII_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module ascii_serial_tx #(
    parameter int BIT_CYCLES = 434,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] char_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 dataOut,
    output logic                 tx_done,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ASCII_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   data_out_q, data_out_d;
    logic                   ready_q, ready_d;
    logic                   tx_done_q, tx_done_d;
    logic                   overrun_q, overrun_d;
`ifdef ASCII_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_out_q <= 1'b1;
            ready_q    <= 1'b1;
            tx_done_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef ASCII_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            tx_done_q  <= tx_done_d;
            overrun_q  <= overrun_d;
`ifdef ASCII_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Outputs are registered, so each branch sets the line level for the state being entered.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_out_d = 1'b1;
        ready_d    = 1'b0;
        tx_done_d  = 1'b0;
`ifdef ASCII_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load && ready_q) begin
                    shift_d    = char_in;
                    state_d    = START;
                    cyc_d      = '0;
                    data_out_d = 1'b0;
`ifdef ASCII_TX_PARITY_EN
                    parity_d   = ^char_in;
`endif
                end else begin
                    ready_d = 1'b1;
                end
            end
            START: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d      = '0;
                    bit_d      = '0;
                    state_d    = DATA;
                    data_out_d = shift_q[0];
                end else begin
                    cyc_d      = cyc_q + CW'(1);
                    data_out_d = 1'b0;
                end
            end
            DATA: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef ASCII_TX_PARITY_EN
                        state_d    = PARITY;
                        data_out_d = parity_q;
`else
                        state_d    = STOP;
                        data_out_d = 1'b1;
`endif
                    end else begin
                        bit_d      = bit_q + BW'(1);
                        data_out_d = shift_q[1];
                    end
                end else begin
                    cyc_d      = cyc_q + CW'(1);
                    data_out_d = shift_q[0];
                end
            end
`ifdef ASCII_TX_PARITY_EN
            PARITY: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    state_d = STOP;
                end else begin
                    cyc_d      = cyc_q + CW'(1);
                    data_out_d = parity_q;
                end
            end
`endif
            STOP: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d     = '0;
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                    ready_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                ready_d = 1'b1;
            end
        endcase
    end

    // A busy load in the same cycle as a clear leaves the flag set.
    always_comb begin
        overrun_d = overrun_q;
        if (load && !ready_q) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    assign dataOut = data_out_q;
    assign ready   = ready_q;
    assign tx_done = tx_done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_ascii_serial_tx.sv
// Directed self-checking bench for ascii_serial_tx with BIT_CYCLES=4, DATA_BITS=8.
module tb_ascii_serial_tx;

    localparam int BC = 4;
`ifdef ASCII_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       load = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       ready, dataOut, tx_done, overrun;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;

    ascii_serial_tx #(.BIT_CYCLES(BC), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .char_in     (char_in),
        .load        (load),
        .ready       (ready),
        .dataOut     (dataOut),
        .tx_done     (tx_done),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Loads c in the current cycle (cycle 0) and checks every cycle of the frame,
    // ending in the tx_done cycle. Optional busy load / clear at given frame cycles.
    task automatic send_frame(input logic [7:0] c, input string tag,
                              input int busy_at, input int clr_at);
        logic [10:0] seq;
`ifdef ASCII_TX_PARITY_EN
        seq = {1'b1, ^c, c, 1'b0};
`else
        seq = {1'b0, 1'b1, c, 1'b0};
`endif
        chk({tag, " ready_before"}, 32'(ready), 32'd1);
        char_in = c;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 1; k <= NBITS * BC; k++) begin
            chk($sformatf("%s dataOut c%0d", tag, k), 32'(dataOut), 32'(seq[(k-1)/BC]));
            chk($sformatf("%s tx_done c%0d", tag, k), 32'(tx_done), 32'd0);
            chk($sformatf("%s ready c%0d", tag, k), 32'(ready), 32'd0);
            if (busy_at > 0 && k == busy_at + 1)
                chk($sformatf("%s overrun_set c%0d", tag, k), 32'(overrun), 32'd1);
            if (k == busy_at) begin
                chk($sformatf("%s overrun_pre c%0d", tag, k), 32'(overrun), 32'd0);
                load = 1'b1;
                char_in = ~c;
            end else begin
                load = 1'b0;
                char_in = 8'($urandom);
            end
            clr_overrun = (k == clr_at);
            tick();
        end
        load = 1'b0;
        clr_overrun = 1'b0;
        chk({tag, " tx_done_end"}, 32'(tx_done), 32'd1);
        chk({tag, " ready_end"}, 32'(ready), 32'd1);
        chk({tag, " dataOut_end"}, 32'(dataOut), 32'd1);
    endtask

    initial begin
        int d0;
        // Reset held 3 cycles, then idle for 20 cycles
        reset = 1'b1;
        repeat (3) tick();
        chk("rst dataOut", 32'(dataOut), 32'd1);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst tx_done", 32'(tx_done), 32'd0);
        chk("rst overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle dataOut", 32'(dataOut), 32'd1);
            chk("idle ready", 32'(ready), 32'd1);
            chk("idle tx_done", 32'(tx_done), 32'd0);
            chk("idle overrun", 32'(overrun), 32'd0);
        end

        // Single frame 'A': bits 1,0,0,0,0,0,1,0 after the start bit
        send_frame(8'h41, "frameA", 0, 0);
        tick();
        chk("frameA tx_done_once", 32'(tx_done), 32'd0);
        chk("frameA ready_idle", 32'(ready), 32'd1);

        // Parity 1 case (plain frame when parity is not built in)
        send_frame(8'h43, "frameC", 0, 0);
        tick();

        // Back-to-back: second load lands in the tx_done cycle
        d0 = done_cnt;
        send_frame(8'h48, "b2b_1", 0, 0);
        send_frame(8'h69, "b2b_2", 0, 0);
        tick();
        chk("b2b done_pulses", 32'(done_cnt - d0), 32'd2);

        // Overrun: busy load at cycle 10, clear at cycle 50
        send_frame(8'h55, "ovr", 10, 0);
        repeat (9) tick();
        chk("ovr still_set c50", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr cleared c51", 32'(overrun), 32'd0);

        // Busy load and clear in the same cycle: set wins
        send_frame(8'h0F, "ovr_pri", 3, 3);
        chk("ovr_pri held", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_pri cleared", 32'(overrun), 32'd0);

        // Reset mid-frame at cycle 15
        d0 = done_cnt;
        char_in = 8'h7E;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst dataOut c16", 32'(dataOut), 32'd1);
        chk("midrst ready c16", 32'(ready), 32'd1);
        chk("midrst tx_done c16", 32'(tx_done), 32'd0);
        for (int i = 0; i < 45; i++) begin
            tick();
            chk("midrst line_idle", 32'(dataOut), 32'd1);
        end
        chk("midrst no_done", 32'(done_cnt - d0), 32'd0);
        send_frame(8'h31, "after_rst", 0, 0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
